// File: rtl/mips_wb_pkg.sv
// Shared writeback definitions: source codes, request payload, sequencer states.
package mips_wb_pkg;

    localparam int unsigned SRC_W = 4;
    localparam int unsigned RD_W  = 5;
    localparam int unsigned CNT_W = 8;

    localparam logic [SRC_W-1:0] SRC_ALU   = 4'd0;
    localparam logic [SRC_W-1:0] SRC_SEXT1 = 4'd1;
    localparam logic [SRC_W-1:0] SRC_SHIFT = 4'd2;
    localparam logic [SRC_W-1:0] SRC_HI    = 4'd3;
    localparam logic [SRC_W-1:0] SRC_LO    = 4'd4;
    localparam logic [SRC_W-1:0] SRC_LUI   = 4'd5;
    localparam logic [SRC_W-1:0] SRC_LOAD  = 4'd6;

    typedef struct packed {
        logic [SRC_W-1:0] src;
        logic [RD_W-1:0]  rd;
    } wb_req_t;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WAIT_MD,
        ST_WAIT_MEM,
        ST_WRITE
    } wb_state_e;

    function automatic logic src_is_legal(input logic [SRC_W-1:0] src);
        return src <= SRC_LOAD;
    endfunction

endpackage

// File: rtl/wb_wait_timer.sv
// Producer wait counter: clear, load, increment, registered terminal count.
module wb_wait_timer
    import mips_wb_pkg::*;
(
    input  logic             clk,
    input  logic             reset_n,
    input  logic             clr_i,
    input  logic             load_i,
    input  logic [CNT_W-1:0] load_val_i,
    input  logic             en_i,
    input  logic [CNT_W-1:0] term_i,
    output logic             tc_o
);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             tc_q;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (load_i) begin
            cnt_d = load_val_i;
        end else if (en_i) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    // Terminal count is precomputed from the next value so it is ready one cycle early.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt_q <= '0;
            tc_q  <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            tc_q  <= (cnt_d == term_i);
        end
    end

    assign tc_o = tc_q;

endmodule

// File: rtl/wb_sequencer.sv
// Register-file writeback sequencer: latches one request, waits on the
// multicycle producer if needed, then issues a single write strobe.
module wb_sequencer
    import mips_wb_pkg::*;
#(
    parameter int unsigned TIMEOUT = 64
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             wb_req,
    input  logic [SRC_W-1:0] wb_src,
    input  logic [RD_W-1:0]  wb_rd,
    output logic             wb_ready,
    input  logic             md_busy,
    input  logic             mem_wait,
    output logic [SRC_W-1:0] src_sel,
    output logic             reg_write,
    output logic [RD_W-1:0]  reg_dst,
    output logic             wb_done,
    output logic             wb_err
);

    wb_state_e state_q, state_d;
    wb_req_t   req_q, req_d;
    logic      ready_q, ready_d;
    logic      write_q, write_d;
    logic      done_q, done_d;
    logic      err_q, err_d;
    logic      tmr_clr, tmr_en, tmr_tc;
    logic      busy;

    wb_wait_timer u_timer (
        .clk        (clk),
        .reset_n    (reset_n),
        .clr_i      (tmr_clr),
        .load_i     (1'b0),
        .load_val_i ('0),
        .en_i       (tmr_en),
        .term_i     (CNT_W'(TIMEOUT - 1)),
        .tc_o       (tmr_tc)
    );

    always_comb begin
        state_d = state_q;
        req_d   = req_q;
        write_d = 1'b0;
        done_d  = 1'b0;
        err_d   = 1'b0;
        tmr_clr = 1'b0;
        tmr_en  = 1'b0;
        busy    = (state_q == ST_WAIT_MD) ? md_busy : mem_wait;

        case (state_q)
            ST_IDLE: begin
                if (wb_req) begin
                    req_d   = '{src: wb_src, rd: wb_rd};
                    tmr_clr = 1'b1;
                    if (!src_is_legal(wb_src)) begin
                        err_d  = 1'b1;
                        done_d = 1'b1;
                    end else if (wb_src == SRC_HI || wb_src == SRC_LO) begin
                        state_d = ST_WAIT_MD;
                    end else if (wb_src == SRC_LOAD) begin
                        state_d = ST_WAIT_MEM;
                    end else begin
                        state_d = ST_WRITE;
                        write_d = (wb_rd != '0);
                        done_d  = 1'b1;
                    end
                end
            end
            // A producer going ready on the timeout edge still gets written.
            ST_WAIT_MD, ST_WAIT_MEM: begin
                if (!busy) begin
                    state_d = ST_WRITE;
                    write_d = (req_q.rd != '0);
                    done_d  = 1'b1;
                end else if (tmr_tc) begin
                    state_d = ST_IDLE;
                    err_d   = 1'b1;
                    done_d  = 1'b1;
                end else begin
                    tmr_en = 1'b1;
                end
            end
            ST_WRITE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        ready_d = (state_d == ST_IDLE);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= ST_IDLE;
            req_q   <= '0;
            ready_q <= 1'b1;
            write_q <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            req_q   <= req_d;
            ready_q <= ready_d;
            write_q <= write_d;
            done_q  <= done_d;
            err_q   <= err_d;
        end
    end

    assign wb_ready  = ready_q;
    assign src_sel   = req_q.src;
    assign reg_dst   = req_q.rd;
    assign reg_write = write_q;
    assign wb_done   = done_q;
    assign wb_err    = err_q;

endmodule

// File: tb/tb_wb_sequencer.sv
// Scoreboard bench for wb_sequencer: two instances (default and short timeout)
// share stimulus; a monitor retires expected outcomes from per-instance queues.
module tb_wb_sequencer;

    typedef struct {
        int unsigned due;
        logic        wr;
        logic [4:0]  dst;
        logic [3:0]  src;
        logic        err;
    } exp_t;

    localparam int unsigned TMO0 = 64;
    localparam int unsigned TMO1 = 4;

    logic       clk = 1'b0;
    logic       reset_n;
    logic       wb_req;
    logic [3:0] wb_src;
    logic [4:0] wb_rd;
    logic       md_busy;
    logic       mem_wait;

    logic       rdy  [2];
    logic [3:0] ssel [2];
    logic       wr   [2];
    logic [4:0] dst  [2];
    logic       done [2];
    logic       err  [2];

    exp_t        q0[$];
    exp_t        q1[$];
    int unsigned cyc = 0;
    int          n_checks = 0;
    int          n_fail = 0;
    logic [3:0]  lat_src = 4'd0;
    logic [4:0]  lat_rd = 5'd0;

    wb_sequencer dut (
        .clk(clk), .reset_n(reset_n), .wb_req(wb_req), .wb_src(wb_src), .wb_rd(wb_rd),
        .wb_ready(rdy[0]), .md_busy(md_busy), .mem_wait(mem_wait), .src_sel(ssel[0]),
        .reg_write(wr[0]), .reg_dst(dst[0]), .wb_done(done[0]), .wb_err(err[0])
    );

    wb_sequencer #(.TIMEOUT(TMO1)) dut_t4 (
        .clk(clk), .reset_n(reset_n), .wb_req(wb_req), .wb_src(wb_src), .wb_rd(wb_rd),
        .wb_ready(rdy[1]), .md_busy(md_busy), .mem_wait(mem_wait), .src_sel(ssel[1]),
        .reg_write(wr[1]), .reg_dst(dst[1]), .wb_done(done[1]), .wb_err(err[1])
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input bit ok, input string what);
        n_checks++;
        if (!ok) begin
            n_fail++;
            $display("FAIL %s", what);
        end
    endtask

    // Outcome of one request from the rules: which edge retires it and how.
    function automatic exp_t model(input logic [3:0] src, input logic [4:0] rd, input int k,
                                   input int unsigned tmo, input int unsigned issue_cyc);
        exp_t        e;
        int unsigned acc = issue_cyc + 1;
        bit          legal = (src <= 4'd6);
        bit          waits = (src == 4'd3 || src == 4'd4 || src == 4'd6);
        e.dst = rd;
        e.src = src;
        e.wr  = 1'b0;
        e.err = 1'b0;
        if (!legal) begin
            e.err = 1'b1;
            e.due = acc;
        end else if (!waits) begin
            e.wr  = (rd != 5'd0);
            e.due = acc;
        end else if (k >= int'(tmo)) begin
            e.err = 1'b1;
            e.due = acc + tmo;
        end else begin
            e.wr  = (rd != 5'd0);
            e.due = acc + int'(k) + 1;
        end
        return e;
    endfunction

    task automatic push(input logic [3:0] src, input logic [4:0] rd, input int k);
        q0.push_back(model(src, rd, k, TMO0, cyc));
        q1.push_back(model(src, rd, k, TMO1, cyc));
    endtask

    task automatic mon(input int id);
        exp_t e;
        bit   empty = (id == 0) ? (q0.size() == 0) : (q1.size() == 0);
        if (done[id]) begin
            if (empty) begin
                check(1'b0, $sformatf("retire[%0d] unexpected wb_done at cyc=%0d, want none", id, cyc));
            end else begin
                if (id == 0) e = q0.pop_front();
                else         e = q1.pop_front();
                check(cyc == e.due && wr[id] == e.wr && dst[id] == e.dst && ssel[id] == e.src && err[id] == e.err,
                      $sformatf("retire[%0d] got cyc=%0d wr=%0b dst=%0d src=%0d err=%0b, want cyc=%0d wr=%0b dst=%0d src=%0d err=%0b",
                                id, cyc, wr[id], dst[id], ssel[id], err[id], e.due, e.wr, e.dst, e.src, e.err));
            end
        end else begin
            check(wr[id] == 1'b0 && err[id] == 1'b0,
                  $sformatf("idle_strobes[%0d] cyc=%0d got wr=%0b err=%0b, want 0 0", id, cyc, wr[id], err[id]));
        end
        check(ssel[id] == lat_src && dst[id] == lat_rd,
              $sformatf("latched[%0d] cyc=%0d got src=%0d dst=%0d, want src=%0d dst=%0d", id, cyc, ssel[id], dst[id], lat_src, lat_rd));
    endtask

    always @(negedge clk) begin
        mon(0);
        mon(1);
    end

    task automatic chk_reset(input string tag);
        for (int i = 0; i < 2; i++) begin
            check(rdy[i] == 1'b1 && ssel[i] == 4'd0 && dst[i] == 5'd0 && wr[i] == 1'b0 && done[i] == 1'b0 && err[i] == 1'b0,
                  $sformatf("%s[%0d] got rdy=%0b src=%0d dst=%0d wr=%0b done=%0b err=%0b, want 1 0 0 0 0 0",
                            tag, i, rdy[i], ssel[i], dst[i], wr[i], done[i], err[i]));
        end
    endtask

    task automatic drain();
        int n = 0;
        while ((q0.size() != 0 || q1.size() != 0) && n < 300) begin
            @(negedge clk);
            #1;
            n++;
        end
        check(q0.size() == 0 && q1.size() == 0,
              $sformatf("drain pending got %0d/%0d, want 0/0", q0.size(), q1.size()));
        q0.delete();
        q1.delete();
        @(negedge clk);
        #1;
        check(rdy[0] && rdy[1], $sformatf("ready_after got %0b/%0b, want 1/1", rdy[0], rdy[1]));
    endtask

    // One request; the matching producer stays busy for k edges after accept,
    // the other producer is held busy to expose a wrong select.
    task automatic issue(input logic [3:0] src, input logic [4:0] rd, input int k);
        bit legal = (src <= 4'd6);
        @(negedge clk);
        wb_req   = 1'b1;
        wb_src   = src;
        wb_rd    = rd;
        md_busy  = (src == 4'd3 || src == 4'd4) ? (k > 0) : 1'b1;
        mem_wait = (src == 4'd6) ? (k > 0) : 1'b1;
        push(src, rd, k);
        @(posedge clk);
        lat_src = src;
        lat_rd  = rd;
        @(negedge clk);
        wb_req = 1'b0;
        #1;
        check(rdy[0] == !legal && rdy[1] == !legal,
              $sformatf("ready_after_accept src=%0d got %0b/%0b, want %0b", src, rdy[0], rdy[1], !legal));
        repeat (k) @(negedge clk);
        md_busy  = 1'b0;
        mem_wait = 1'b0;
        drain();
    endtask

    initial begin
        int unsigned dues[3];
        reset_n  = 1'b0;
        wb_req   = 1'b0;
        wb_src   = 4'd0;
        wb_rd    = 5'd0;
        md_busy  = 1'b0;
        mem_wait = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        chk_reset("reset_values");
        #1;
        reset_n = 1'b1;

        issue(4'd0, 5'd8, 0);
        issue(4'd3, 5'd9, 5);
        issue(4'd6, 5'd12, 100);
        issue(4'd9, 5'd3, 0);
        issue(4'd0, 5'd0, 0);
        issue(4'd3, 5'd10, 0);
        issue(4'd6, 5'd5, 3);
        issue(4'd4, 5'd7, 4);
        issue(4'd5, 5'd31, 0);
        issue(4'd1, 5'd2, 0);
        issue(4'd2, 5'd4, 0);
        issue(4'd15, 5'd0, 0);
        issue(4'd4, 5'd0, 2);

        // Reset in the middle of a HI wait drops the request silently.
        @(negedge clk);
        wb_req  = 1'b1;
        wb_src  = 4'd3;
        wb_rd   = 5'd9;
        md_busy = 1'b1;
        @(posedge clk);
        lat_src = 4'd3;
        lat_rd  = 5'd9;
        @(negedge clk);
        wb_req = 1'b0;
        repeat (3) @(negedge clk);
        #2;
        reset_n = 1'b0;
        lat_src = 4'd0;
        lat_rd  = 5'd0;
        #1;
        chk_reset("async_reset");
        @(negedge clk);
        #2;
        reset_n = 1'b1;
        md_busy = 1'b0;
        issue(4'd0, 5'd17, 0);

        // Back-to-back with wb_req held high.
        @(negedge clk);
        wb_req = 1'b1;
        wb_src = 4'd0;
        for (int i = 0; i < 3; i++) begin
            int n = 0;
            while (!(rdy[0] && rdy[1]) && n < 10) begin
                @(negedge clk);
                n++;
            end
            check(rdy[0] && rdy[1], $sformatf("b2b_ready[%0d] got %0b/%0b, want 1/1", i, rdy[0], rdy[1]));
            wb_rd   = 5'(i + 1);
            dues[i] = cyc + 1;
            push(4'd0, 5'(i + 1), 0);
            @(posedge clk);
            lat_src = 4'd0;
            lat_rd  = 5'(i + 1);
            @(negedge clk);
        end
        wb_req = 1'b0;
        check(dues[1] == dues[0] + 2 && dues[2] == dues[0] + 4,
              $sformatf("b2b_spacing got %0d,%0d,%0d, want step 2", dues[0], dues[1], dues[2]));
        drain();

        for (int i = 0; i < 40; i++) begin
            int unsigned r   = $urandom_range(0, 9);
            logic [3:0]  src = (r < 7) ? 4'(r) : 4'($urandom_range(7, 15));
            logic [4:0]  rd  = 5'($urandom_range(0, 31));
            int          k   = ($urandom_range(0, 9) == 0) ? 70 : int'($urandom_range(0, 7));
            issue(src, rd, k);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/wb_sequencer.md
# wb_sequencer

Register-file writeback sequencer for the multicycle MIPS core. It accepts one writeback request at a time, holding the source select and destination register stable. It waits for multi-cycle producers before writing: mult/div for HI/LO, and the load/store unit for load data. It then drives the writeback data mux select and emits a single-cycle register-write strobe. It sits between the main control FSM and the register-file write port, and replaces direct control-FSM drive of the mux select.

## Interface
- `TIMEOUT`, default 64: maximum cycles spent waiting on a producer before the request is abandoned; legal range 1..255.
- `clk`  in  1  core clock; all state updates on rising edge.
- `reset_n`  in  1  asynchronous, active-low reset.
- `wb_req`  in  1  request valid from control FSM.
- `wb_src`  in  4  requested source: 0 ALU, 1 sign-extend-1, 2 shifter, 3 HI, 4 LO, 5 LUI (shift-left-16), 6 load data; 7..15 illegal.
- `wb_rd`  in  5  destination register number.
- `wb_ready`  out  1  high when a request can be accepted.
- `md_busy`  in  1  high while mult/div result (HI/LO) not yet valid.
- `mem_wait`  in  1  high while load data not yet valid.
- `src_sel`  out  4  writeback mux select.
- `reg_write`  out  1  one-cycle register-file write enable.
- `reg_dst`  out  5  register-file write address.
- `wb_done`  out  1  one-cycle pulse when a request retires, written or not.
- `wb_err`  out  1  one-cycle pulse on illegal source or timeout.

## Operation
- States: IDLE, WAIT_MD, WAIT_MEM, WRITE.
- `wb_ready` = (state == IDLE). A request is accepted on a rising edge when `wb_req && wb_ready`.
- On accept, `wb_src` and `wb_rd` are latched into `src_sel` and `reg_dst`. Both hold until the next accept.
- Transitions on accept:
  - src 0, 1, 2, 5 → WRITE.
  - src 3 or 4 → WAIT_MD.
  - src 6 → WAIT_MEM.
  - src 7..15 → IDLE, with `wb_err` and `wb_done` pulsed next cycle and no write.
- WAIT_MD:
  - `md_busy` low → WRITE.
  - Wait counter reaching `TIMEOUT` → IDLE, with `wb_err` and `wb_done` pulsed and no write.
- WAIT_MEM: same rules as WAIT_MD, using `mem_wait`.
- Wait counter: width 8. Cleared on entry to a wait state, incremented each cycle the producer stays busy. Timeout fires when counter == `TIMEOUT`-1 while the producer is still busy.
- WRITE:
  - `reg_write` = 1, except 0 when `reg_dst` == 0 (writes to $zero suppressed).
  - `wb_done` = 1.
  - Next state IDLE.
- `wb_req` is ignored when not ready; the requester must hold it until `wb_ready` is observed high.

## Timing
- All outputs registered or decoded purely from state and latched registers; no combinational path from inputs to outputs.
- Reset values: state IDLE, `wb_ready` 1, `src_sel` 0, `reg_dst` 0, `reg_write` 0, `wb_done` 0, `wb_err` 0, counter 0.
- Latency, no wait: accept at edge N; WRITE cycle follows, with `reg_write` high between edges N and N+1; `wb_ready` high again after edge N+1. Throughput is one writeback per 2 cycles.
- Latency with wait: the WRITE cycle follows the first edge at which the producer's busy signal is sampled low.
- Busy already low at accept: one WAIT cycle, then WRITE, so total latency is 2 cycles.
- Asynchronous reset mid-wait or mid-WRITE:
  - Immediately forces IDLE and clears `reg_write`.
  - The in-flight request is dropped without `wb_done`.
- Timeout and busy deasserting on the same edge: busy wins, so WRITE is taken with no error.

## Structure
- Shared package `mips_wb_pkg` holds:
  - source codes SRC_ALU..SRC_LOAD (4-bit constants 0..6);
  - the state enum;
  - a `src_is_legal` function.
- The control FSM and the writeback mux use the same package constants.
- One sub-module, `wb_wait_timer`: loadable 8-bit wait counter with clear, enable and terminal-count output.

## Test plan
- Reset then ALU request:
  - Stimulus: `wb_req`=1, src 0, rd 8.
  - Response: next cycle `reg_write`=1, `reg_dst`=8, `src_sel`=0, `wb_done`=1; `wb_ready` low for exactly 1 cycle.
- HI request with mult/div busy:
  - Stimulus: src 3, rd 9, `md_busy` high for 5 cycles after accept.
  - Response: `reg_write` pulses in cycle 6; `src_sel`=3 throughout.
- Load request timeout:
  - Stimulus: `TIMEOUT`=4, src 6, `mem_wait` stuck high.
  - Response: after 4 wait cycles, `wb_err` and `wb_done` pulse, `reg_write` never asserts, `wb_ready` returns high.
- Illegal and $zero requests:
  - Stimulus: src 9; then src 0 with rd 0.
  - Response (src 9): `wb_err` pulse, no write.
  - Response (rd 0): `wb_done` pulse with `reg_write`=0.
- Reset mid-wait:
  - Stimulus: `reset_n` low during WAIT_MD.
  - Response: all outputs at reset values asynchronously, no `wb_done`; the next request is serviced normally.
- Back-to-back:
  - Stimulus: `wb_req` held high with src 0 and rd 1, 2, 3 changing on each accept.
  - Response: writes to 1, 2, 3 on alternate cycles.
